// File: rtl/i2c_oled_target.sv
// i2c_oled_target: write-only I2C target for an SSD1306-style OLED front end.
// Oversamples the raw bus with clk, acknowledges its own address, splits the
// stream into control and payload bytes, and reports each payload byte with
// its D/C flag.
module i2c_oled_target #(
  parameter logic [6:0] ADDR = 7'h3C
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sck,
  input  logic        sda_in,
  output logic        sda_oe,
  output logic [7:0]  byte_data,
  output logic        byte_dc,
  output logic        byte_valid,
  output logic        busy,
  output logic        nack_seen,
  output logic [15:0] byte_count
);

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ADDR     = 3'd1,
    ST_ADDR_ACK = 3'd2,
    ST_CTRL     = 3'd3,
    ST_CTRL_ACK = 3'd4,
    ST_DATA     = 3'd5,
    ST_DATA_ACK = 3'd6,
    ST_IGNORE   = 3'd7
  } state_t;

  // synchronizer and history flops (idle bus is high on both lines)
  logic [1:0] sck_sync_r;
  logic [1:0] sda_sync_r;
  logic       sck_hist_r;
  logic       sda_hist_r;

  // bus events derived from the synchronized lines
  logic sck_s, sda_s;
  logic sck_rise_s, sck_fall_s, start_s, stop_s;

  // protocol state and its next-state values
  state_t      state_r, state_s;
  logic [2:0]  bit_cnt_r, bit_cnt_s;
  logic [7:0]  shift_r, shift_s;
  logic        dc_r, dc_s;
  logic        co_r, co_s;
  logic        ack_on_r, ack_on_s;
  logic        sda_oe_s;
  logic [7:0]  byte_data_s;
  logic        byte_dc_s;
  logic        byte_valid_s;
  logic        busy_s;
  logic        nack_seen_s;
  logic [15:0] byte_count_s;
  logic        byte_done_s;
  logic [7:0]  full_byte_s;
  logic        shifting_s;
  state_t      ack_next_s;

  // bring sck/sda into the clk domain and keep one cycle of history
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_sync_r <= 2'b11;
      sda_sync_r <= 2'b11;
      sck_hist_r <= 1'b1;
      sda_hist_r <= 1'b1;
    end else begin
      sck_sync_r <= {sck_sync_r[0], sck};
      sda_sync_r <= {sda_sync_r[0], sda_in};
      sck_hist_r <= sck_sync_r[1];
      sda_hist_r <= sda_sync_r[1];
    end
  end

  assign sck_s      = sck_sync_r[1];
  assign sda_s      = sda_sync_r[1];
  assign sck_rise_s = sck_s & ~sck_hist_r;
  assign sck_fall_s = ~sck_s & sck_hist_r;
  // sda may only move while sck is low during a byte; a move while sck is
  // high on both samples is a START (falling) or STOP (rising)
  assign start_s    = sck_s & sck_hist_r & sda_hist_r & ~sda_s;
  assign stop_s     = sck_s & sck_hist_r & ~sda_hist_r & sda_s;
  assign full_byte_s = {shift_r[6:0], sda_s};

  // register the protocol state and all outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      bit_cnt_r  <= 3'd0;
      shift_r    <= 8'h00;
      dc_r       <= 1'b0;
      co_r       <= 1'b0;
      ack_on_r   <= 1'b0;
      sda_oe     <= 1'b0;
      byte_data  <= 8'h00;
      byte_dc    <= 1'b0;
      byte_valid <= 1'b0;
      busy       <= 1'b0;
      nack_seen  <= 1'b0;
      byte_count <= 16'h0000;
    end else begin
      state_r    <= state_s;
      bit_cnt_r  <= bit_cnt_s;
      shift_r    <= shift_s;
      dc_r       <= dc_s;
      co_r       <= co_s;
      ack_on_r   <= ack_on_s;
      sda_oe     <= sda_oe_s;
      byte_data  <= byte_data_s;
      byte_dc    <= byte_dc_s;
      byte_valid <= byte_valid_s;
      busy       <= busy_s;
      nack_seen  <= nack_seen_s;
      byte_count <= byte_count_s;
    end
  end

  // next-state and output decode; STOP beats START beats normal bit handling
  always_comb begin
    state_s      = state_r;
    bit_cnt_s    = bit_cnt_r;
    shift_s      = shift_r;
    dc_s         = dc_r;
    co_s         = co_r;
    ack_on_s     = ack_on_r;
    sda_oe_s     = sda_oe;
    byte_data_s  = byte_data;
    byte_dc_s    = byte_dc;
    byte_valid_s = 1'b0;
    busy_s       = busy;
    nack_seen_s  = 1'b0;
    byte_count_s = byte_count;
    byte_done_s  = 1'b0;
    shifting_s   = (state_r == ST_ADDR) || (state_r == ST_CTRL) || (state_r == ST_DATA);

    // where each acknowledge slot hands over once the 9th clock ends
    case (state_r)
      ST_ADDR_ACK: ack_next_s = ST_CTRL;
      ST_CTRL_ACK: ack_next_s = ST_DATA;
      ST_DATA_ACK: ack_next_s = co_r ? ST_CTRL : ST_DATA;
      default:     ack_next_s = ST_IDLE;
    endcase

    if (stop_s) begin
      state_s   = ST_IDLE;
      bit_cnt_s = 3'd0;
      ack_on_s  = 1'b0;
      sda_oe_s  = 1'b0;
      busy_s    = 1'b0;
    end else if (start_s) begin
      // busy survives a repeated START; a later mismatch clears it
      state_s   = ST_ADDR;
      bit_cnt_s = 3'd0;
      ack_on_s  = 1'b0;
      sda_oe_s  = 1'b0;
    end else begin
      if (sck_rise_s && shifting_s) begin
        shift_s = full_byte_s;
        if (bit_cnt_r == 3'd7) begin
          bit_cnt_s   = 3'd0;
          byte_done_s = 1'b1;
        end else begin
          bit_cnt_s = bit_cnt_r + 3'd1;
        end
      end else begin
        shift_s = shift_r;
      end

      case (state_r)
        ST_ADDR: begin
          if (byte_done_s) begin
            if ((full_byte_s[7:1] == ADDR) && !full_byte_s[0]) begin
              state_s = ST_ADDR_ACK;
              busy_s  = 1'b1;
            end else begin
              state_s     = ST_IGNORE;
              nack_seen_s = 1'b1;
              busy_s      = 1'b0;
            end
          end else begin
            state_s = ST_ADDR;
          end
        end
        ST_CTRL: begin
          if (byte_done_s) begin
            co_s    = full_byte_s[7];
            dc_s    = full_byte_s[6];
            state_s = ST_CTRL_ACK;
          end else begin
            state_s = ST_CTRL;
          end
        end
        ST_DATA: begin
          if (byte_done_s) begin
            byte_data_s  = full_byte_s;
            byte_dc_s    = dc_r;
            byte_valid_s = 1'b1;
            byte_count_s = (byte_count == 16'hFFFF) ? 16'hFFFF : byte_count + 16'd1;
            state_s      = ST_DATA_ACK;
          end else begin
            state_s = ST_DATA;
          end
        end
        ST_ADDR_ACK, ST_CTRL_ACK, ST_DATA_ACK: begin
          // first falling edge pulls SDA low, the next one releases it
          if (sck_fall_s) begin
            if (!ack_on_r) begin
              sda_oe_s = 1'b1;
              ack_on_s = 1'b1;
            end else begin
              sda_oe_s  = 1'b0;
              ack_on_s  = 1'b0;
              bit_cnt_s = 3'd0;
              state_s   = ack_next_s;
            end
          end else begin
            sda_oe_s = sda_oe;
          end
        end
        ST_IGNORE: begin
          sda_oe_s = 1'b0;
        end
        default: begin
          state_s = state_r;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_oled_target.sv
// Self-checking bench for i2c_oled_target: a bit-banged I2C master drives the
// bus, a monitor records DUT pulses, and a transaction-level model predicts the
// delivered bytes from the address/control-byte rules.
module tb_i2c_oled_target;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        sck = 1'b1;
  logic        msda = 1'b1;
  logic        sda_in;
  logic        sda_oe;
  logic [7:0]  byte_data;
  logic        byte_dc;
  logic        byte_valid;
  logic        busy;
  logic        nack_seen;
  logic [15:0] byte_count;

  // open-drain bus: the master releases high, the target can only pull low
  assign sda_in = msda & ~sda_oe;

  i2c_oled_target #(.ADDR(7'h3C)) dut (
    .clk(clk), .rst(rst), .sck(sck), .sda_in(sda_in), .sda_oe(sda_oe),
    .byte_data(byte_data), .byte_dc(byte_dc), .byte_valid(byte_valid),
    .busy(busy), .nack_seen(nack_seen), .byte_count(byte_count)
  );

  initial forever #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int oe_pulses, nack_pulses, overlap, master_acks, exp_count;
  logic oe_prev = 1'b0;
  logic [8:0] got_q[$];
  logic [8:0] exp_q[$];

  typedef struct {
    logic [7:0] b [6];
    int n;
    int acks;
    int nacks;
    int nvalid;
  } vec_t;
  vec_t vecs[5];

  // monitor DUT pulses away from the active edge
  initial forever begin
    @(negedge clk);
    if (sda_oe && !oe_prev) oe_pulses++;
    oe_prev = sda_oe;
    if (byte_valid) got_q.push_back({byte_dc, byte_data});
    if (nack_seen) nack_pulses++;
    if (byte_valid && nack_seen) overlap++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic bus_start();
    #40 msda = 1'b1;
    #40 sck = 1'b1;
    #40 msda = 1'b0;
    #40 sck = 1'b0;
  endtask

  task automatic bus_stop();
    #40 msda = 1'b0;
    #40 sck = 1'b1;
    #40 msda = 1'b1;
    #40;
  endtask

  task automatic send_bit(input logic b);
    #40 msda = b;
    #40 sck = 1'b1;
    #80 sck = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    #40 msda = 1'b1;
    #40 sck = 1'b1;
    #40 if (sda_in == 1'b0) master_acks++;
    #40 sck = 1'b0;
  endtask

  // transaction-level model: who is addressed, then control/data parsing
  task automatic model_txn(input logic [7:0] bs[6], input int n, output int acks, output int nacks);
    logic want_ctrl;
    logic dc, co;
    logic [7:0] b;
    exp_q.delete();
    b = bs[0];
    if (b[7:1] != 7'h3C || b[0]) begin
      acks = 0;
      nacks = 1;
    end else begin
      acks = n;
      nacks = 0;
      want_ctrl = 1'b1;
      dc = 1'b0;
      co = 1'b0;
      for (int i = 1; i < n; i++) begin
        b = bs[i];
        if (want_ctrl) begin
          co = b[7];
          dc = b[6];
          want_ctrl = 1'b0;
        end else begin
          exp_q.push_back({dc, b});
          want_ctrl = co;
        end
      end
    end
  endtask

  task automatic clear_mon();
    got_q.delete();
    oe_pulses = 0;
    nack_pulses = 0;
    overlap = 0;
    master_acks = 0;
  endtask

  task automatic compare_bytes(input int exp_valid);
    check("valid_count", got_q.size(), exp_valid);
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      check("byte_dc_data", {23'd0, got_q[i]}, {23'd0, exp_q[i]});
    exp_count = exp_count + exp_q.size();
    if (exp_count > 65535) exp_count = 65535;
    check("byte_count", byte_count, exp_count);
    check("overlap", overlap, 0);
  endtask

  task automatic run_txn(input logic [7:0] bs[6], input int n, input int acks, input int nacks, input int nvalid);
    logic busy_mid;
    int m_acks, m_nacks;
    clear_mon();
    model_txn(bs, n, m_acks, m_nacks);
    bus_start();
    for (int i = 0; i < n; i++) send_byte(bs[i]);
    busy_mid = busy;
    bus_stop();
    #200;
    check("ack_pulses", oe_pulses, acks);
    check("master_acks", master_acks, acks);
    check("nack_pulses", nack_pulses, nacks);
    check("busy_mid", {31'd0, busy_mid}, (acks > 0) ? 32'd1 : 32'd0);
    check("busy_after_stop", {31'd0, busy}, 32'd0);
    compare_bytes(nvalid);
  endtask

  task automatic set_vec(input int k, input logic [7:0] b0, input logic [7:0] b1, input logic [7:0] b2,
                         input logic [7:0] b3, input logic [7:0] b4, input int n, input int acks,
                         input int nacks, input int nvalid);
    vecs[k].b[0] = b0; vecs[k].b[1] = b1; vecs[k].b[2] = b2;
    vecs[k].b[3] = b3; vecs[k].b[4] = b4; vecs[k].b[5] = 8'h00;
    vecs[k].n = n; vecs[k].acks = acks; vecs[k].nacks = nacks; vecs[k].nvalid = nvalid;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_sda_oe"}, {31'd0, sda_oe}, 32'd0);
    check({tag, "_byte_valid"}, {31'd0, byte_valid}, 32'd0);
    check({tag, "_nack_seen"}, {31'd0, nack_seen}, 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_byte_data"}, {24'd0, byte_data}, 32'd0);
    check({tag, "_byte_dc"}, {31'd0, byte_dc}, 32'd0);
    check({tag, "_byte_count"}, {16'd0, byte_count}, 32'd0);
  endtask

  initial begin
    logic [7:0] bs[6];
    int acks, nacks, sel, n;
    exp_count = 0;
    clear_mon();

    set_vec(0, 8'h78, 8'h00, 8'hAE, 8'hAF, 8'h00, 4, 4, 0, 2);
    set_vec(1, 8'h78, 8'h40, 8'h55, 8'hAA, 8'hFF, 5, 5, 0, 3);
    set_vec(2, 8'h7A, 8'h00, 8'h12, 8'h34, 8'h00, 4, 0, 1, 0);
    set_vec(3, 8'h79, 8'h00, 8'h12, 8'h00, 8'h00, 3, 0, 1, 0);
    set_vec(4, 8'h78, 8'h80, 8'h8D, 8'h40, 8'h12, 5, 5, 0, 2);

    #2;
    #50 check_reset_outputs("reset");
    rst = 1'b0;
    #100;

    // table-driven transactions
    for (int k = 0; k < 5; k++)
      run_txn(vecs[k].b, vecs[k].n, vecs[k].acks, vecs[k].nacks, vecs[k].nvalid);

    // partial data byte aborted by a repeated START
    clear_mon();
    bus_start();
    send_byte(8'h78);
    send_byte(8'h00);
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    bus_start();
    send_byte(8'h78);
    send_byte(8'h00);
    send_byte(8'hA5);
    bus_stop();
    #200;
    exp_q.delete();
    exp_q.push_back({1'b0, 8'hA5});
    check("rs_ack_pulses", oe_pulses, 5);
    check("rs_nack_pulses", nack_pulses, 0);
    compare_bytes(1);

    // reset asserted while the target acknowledges a data byte
    clear_mon();
    bus_start();
    send_byte(8'h78);
    send_byte(8'h00);
    for (int i = 7; i >= 0; i--) send_bit(i[0]);
    #41 check("oe_in_data_ack", {31'd0, sda_oe}, 32'd1);
    rst = 1'b1;
    #1 check("oe_async_drop", {31'd0, sda_oe}, 32'd0);
    #20 check_reset_outputs("midrst");
    rst = 1'b0;
    exp_count = 0;
    #100;
    bs = '{8'h78, 8'h40, 8'h5A, 8'h00, 8'h00, 8'h00};
    run_txn(bs, 3, 3, 0, 1);

    // randomized transactions against the model
    for (int r = 0; r < 12; r++) begin
      n = $urandom_range(2, 6);
      sel = $urandom_range(0, 9);
      for (int i = 0; i < 6; i++) bs[i] = 8'($urandom);
      if (sel < 7) bs[0] = 8'h78;
      else if (sel == 7) bs[0] = 8'h79;
      model_txn(bs, n, acks, nacks);
      run_txn(bs, n, acks, nacks, exp_q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
